fifo_wr_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single write port of the async FIFO among NUM_REQ requesters in the wr_clk domain.

---
 rtl/fifo_wr_arbiter_pkg.sv | 25 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 41 ++++
 rtl/fifo_wr_arbiter.sv | 127 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
// Holds the lock FSM state encodings, the default word width and a clog2
// helper that the top uses to check its parameters at elaboration.
// The burst-lock feature is enabled by defining FIFO_WR_ARB_LOCK_EN.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // Ceiling log2 with a minimum of 1, so a two-source arbiter still
  // gets a one-bit index.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority encoder for the write-port arbiter.
// Searches req upward from index 'start', wrapping at NUM_REQ, and returns
// the first requesting source as a one-hot grant plus its binary index.
module fifo_wr_arbiter_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] pos;

  // Walk every offset from the start index and keep the first hit.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    sum = '0;
    pos = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, start} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      pos = sum[IDX_W-1:0];
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ
// sources in the wr_clk domain. One source is granted per ready cycle and
// its word is registered into a one-deep stage that drives the FIFO; the
// stage holds its word while fifo_full is high, so nothing is dropped.
// Define FIFO_WR_ARB_LOCK_EN to keep the grant on one source for a whole
// burst (until a beat with req_last=1 is accepted).
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int IDX_W      = 2
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [IDX_W-1:0]              fifo_wr_src,
  output logic                          busy
);

  if (IDX_W != clog2(NUM_REQ)) begin : g_idx_check
    $error("fifo_wr_arbiter: IDX_W must equal clog2(NUM_REQ)");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_num_check
    $error("fifo_wr_arbiter: NUM_REQ must be in 2..8");
  end

  logic [DATA_WIDTH-1:0] src_word [NUM_REQ];
  logic [NUM_REQ-1:0]    req_eff;
  logic [NUM_REQ-1:0]    pick_gnt;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      rr_ptr_next;
  logic                  stage_rdy;
  logic                  accept;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_word
    assign src_word[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  fifo_wr_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req_eff),
    .start (rr_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // rr_ptr is the next index to search from, i.e. one past the last grant.
  assign stage_rdy   = !fifo_wr_en || !fifo_full;
  assign accept      = stage_rdy && pick_any && wr_rst;
  assign gnt         = accept ? pick_gnt : '0;
  assign rr_ptr_next = (pick_idx == IDX_W'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;

  // Output stage: load on accept, empty on a drain with nothing behind it.
  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      fifo_wr_src  <= '0;
      rr_ptr       <= '0;
    end else if (accept) begin
      fifo_wr_en   <= 1'b1;
      fifo_wr_data <= src_word[pick_idx];
      fifo_wr_src  <= pick_idx;
      rr_ptr       <= rr_ptr_next;
    end else if (fifo_wr_en && !fifo_full) begin
      fifo_wr_en   <= 1'b0;
    end
  end

`ifdef FIFO_WR_ARB_LOCK_EN
  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] lock_src_q, lock_src_d;

  assign req_eff = (state_q == ST_LOCK) ? (req & (NUM_REQ'(1) << lock_src_q)) : req;
  assign busy    = fifo_wr_en || (state_q == ST_LOCK);

  // Lock state register.
  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      state_q    <= ST_IDLE;
      lock_src_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_src_q <= lock_src_d;
    end
  end

  // Enter LOCK on a non-final beat, leave on the locked source's last beat.
  always_comb begin
    state_d    = state_q;
    lock_src_d = lock_src_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && !req_last[pick_idx]) begin
          state_d    = ST_LOCK;
          lock_src_d = pick_idx;
        end
      end
      ST_LOCK: begin
        if (accept && req_last[pick_idx]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
`else
  logic unused_last;

  assign req_eff     = req;
  assign busy        = fifo_wr_en;
  assign unused_last = ^req_last;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and scoreboard bench for fifo_wr_arbiter (NUM_REQ=4, 8-bit words).
// Honours FIFO_WR_ARB_LOCK_EN for the burst-lock step.
module tb_fifo_wr_arbiter;

  logic        wr_clk;
  logic        wr_rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  gnt;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic [1:0]  fifo_wr_src;
  logic        busy;

  int vectors;
  int miscompares;

  logic [9:0]  expQ [$];
  logic [9:0]  expWord;
  logic        srcReq [4];
  logic [7:0]  srcData [4];
  logic [3:0]  taken;

  fifo_wr_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .IDX_W      (2)
  ) dut (
    .wr_clk       (wr_clk),
    .wr_rst       (wr_rst),
    .req          (req),
    .req_data     (req_data),
    .req_last     (req_last),
    .gnt          (gnt),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_src  (fifo_wr_src),
    .busy         (busy)
  );

  // Free-running write clock, rising edges at 5, 15, 25, ...
  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] last, input logic full);
    req       = r;
    req_last  = last;
    fifo_full = full;
    #1;
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic checkStage(input string tag, input logic en, input logic [7:0] data, input logic [1:0] src);
    checkOutput({tag, "_en"}, fifo_wr_en, en);
    checkOutput({tag, "_data"}, fifo_wr_data, data);
    checkOutput({tag, "_src"}, fifo_wr_src, src);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    taken       = '0;
    for (int i = 0; i < 4; i++) begin
      srcReq[i]  = 1'b0;
      srcData[i] = '0;
    end
    wr_rst    = 1'b0;
    req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req       = 4'b1111;
    req_last  = 4'b1111;
    fifo_full = 1'b0;

    // Reset state, with requests already pending
    #6;
    checkStage("rst", 1'b0, 8'h00, 2'd0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_gnt", gnt, 4'b0000);

    // All four requesting: rotating grants, continuous writes
    wr_rst = 1'b1;
    #1;
    checkOutput("rr_gnt0", gnt, 4'b0001);
    tick();
    checkStage("rr_w0", 1'b1, 8'hA0, 2'd0);
    checkOutput("rr_busy", busy, 1'b1);
    checkOutput("rr_gnt1", gnt, 4'b0010);
    tick();
    checkStage("rr_w1", 1'b1, 8'hA1, 2'd1);
    checkOutput("rr_gnt2", gnt, 4'b0100);
    tick();
    checkStage("rr_w2", 1'b1, 8'hA2, 2'd2);
    checkOutput("rr_gnt3", gnt, 4'b1000);
    tick();
    checkStage("rr_w3", 1'b1, 8'hA3, 2'd3);
    checkOutput("rr_gnt_wrap", gnt, 4'b0001);
    tick();
    checkStage("rr_w4", 1'b1, 8'hA0, 2'd0);

    // FIFO full for five cycles holds the stage and blocks grants
    applyStimulus(4'b0101, 4'b1111, 1'b1);
    checkOutput("full_gnt", gnt, 4'b0000);
    repeat (5) begin
      tick();
      checkStage("full_hold", 1'b1, 8'hA0, 2'd0);
      checkOutput("full_hold_gnt", gnt, 4'b0000);
    end
    applyStimulus(4'b0101, 4'b1111, 1'b0);
    checkOutput("unfull_gnt", gnt, 4'b0100);
    tick();
    checkStage("unfull_w", 1'b1, 8'hA2, 2'd2);
    checkOutput("unfull_gnt_next", gnt, 4'b0001);
    applyStimulus(4'b0000, 4'b1111, 1'b0);
    checkOutput("idle_gnt", gnt, 4'b0000);
    tick();
    checkOutput("idle_en", fifo_wr_en, 1'b0);
    checkOutput("idle_busy", busy, 1'b0);

    // Single requester granted on every ready cycle
    for (int k = 0; k < 6; k++) begin
      req_data[31:24] = 8'hB0 + 8'(k);
      applyStimulus(4'b1000, 4'b1111, 1'b0);
      checkOutput("single_gnt", gnt, 4'b1000);
      tick();
      checkStage("single_w", 1'b1, 8'hB0 + 8'(k), 2'd3);
    end

    // Asynchronous reset mid-stream clears outputs and the pointer
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    applyStimulus(4'b0010, 4'b1111, 1'b0);
    checkOutput("pre_rst_gnt", gnt, 4'b0010);
    tick();
    checkStage("pre_rst_w", 1'b1, 8'hA1, 2'd1);
    #2;
    wr_rst = 1'b0;
    #1;
    checkStage("async_rst", 1'b0, 8'h00, 2'd0);
    checkOutput("async_rst_busy", busy, 1'b0);
    checkOutput("async_rst_gnt", gnt, 4'b0000);
    req = 4'b1111;
    tick();
    wr_rst = 1'b1;
    #1;
    checkOutput("post_rst_gnt", gnt, 4'b0001);
    tick();
    checkStage("post_rst_w", 1'b1, 8'hA0, 2'd0);

    // Source 1 bursts three beats while sources 0 and 2 also request
    applyStimulus(4'b0111, 4'b1101, 1'b0);
    checkOutput("burst_gnt0", gnt, 4'b0010);
    tick();
    checkStage("burst_w0", 1'b1, 8'hA1, 2'd1);
    checkOutput("burst_busy", busy, 1'b1);
`ifdef FIFO_WR_ARB_LOCK_EN
    checkOutput("lock_gnt1", gnt, 4'b0010);
    tick();
    checkOutput("lock_src1", fifo_wr_src, 2'd1);
    applyStimulus(4'b0111, 4'b1111, 1'b0);
    checkOutput("lock_gnt2", gnt, 4'b0010);
    tick();
    checkOutput("lock_src2", fifo_wr_src, 2'd1);
    checkOutput("unlock_gnt", gnt, 4'b0100);
`else
    checkOutput("rr_burst_gnt1", gnt, 4'b0100);
    tick();
    checkOutput("rr_burst_src1", fifo_wr_src, 2'd2);
    checkOutput("rr_burst_gnt2", gnt, 4'b0001);
    tick();
    checkOutput("rr_burst_src2", fifo_wr_src, 2'd0);
    checkOutput("rr_burst_gnt3", gnt, 4'b0010);
`endif
    applyStimulus(4'b0000, 4'b1111, 1'b0);
    tick();
    tick();
    checkOutput("drain_idle_en", fifo_wr_en, 1'b0);

    // Random traffic against an in-order scoreboard
    for (int n = 0; n < 2000; n++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (!srcReq[i] || taken[i]) begin
          srcReq[i]  = ($urandom_range(0, 2) != 0);
          srcData[i] = 8'($urandom);
        end
        req[i]            = srcReq[i];
        req_data[i*8 +: 8] = srcData[i];
      end
      req_last  = 4'b1111;
      fifo_full = ($urandom_range(0, 3) == 0);
      #1;
      checkOutput("rand_onehot", 32'($onehot0(gnt)), 32'd1);
      checkOutput("rand_wr_en", fifo_wr_en, expQ.size() != 0);
      if (fifo_wr_en && !fifo_full && expQ.size() != 0) begin
        expWord = expQ.pop_front();
        checkOutput("rand_word", {fifo_wr_src, fifo_wr_data}, expWord);
      end
      taken = req & gnt;
      for (int i = 0; i < 4; i++) begin
        if (taken[i]) expQ.push_back({2'(i), srcData[i]});
      end
    end
    tick();
    req       = 4'b0000;
    fifo_full = 1'b0;
    #1;
    checkOutput("final_wr_en", fifo_wr_en, expQ.size() != 0);
    if (fifo_wr_en && expQ.size() != 0) begin
      expWord = expQ.pop_front();
      checkOutput("final_word", {fifo_wr_src, fifo_wr_data}, expWord);
    end
    tick();
    checkOutput("final_empty_en", fifo_wr_en, 1'b0);
    checkOutput("final_queue", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
